// File: rtl/bsg_logic_op_pkg.sv
// Shared types and the bitwise evaluation function for the pipelined logic unit.
// The function works on a maximum-width word; callers zero-extend and slice.
package bsg_logic_op_pkg;

    localparam int unsigned bsg_logic_op_max_width_gp = 1024;

    typedef enum logic [2:0] {
        LogicAnd   = 3'd0,
        LogicOr    = 3'd1,
        LogicXor   = 3'd2,
        LogicNand  = 3'd3,
        LogicNor   = 3'd4,
        LogicXnor  = 3'd5,
        LogicAndn  = 3'd6,
        LogicPassA = 3'd7
    } bsg_logic_op_e;

    typedef logic [bsg_logic_op_max_width_gp-1:0] bsg_logic_word_t;

    function automatic bsg_logic_word_t bsg_logic_op_eval(input bsg_logic_word_t a,
                                                          input bsg_logic_word_t b,
                                                          input bsg_logic_op_e   op);
        bsg_logic_word_t r;
        case (op)
            LogicAnd:   r = a & b;
            LogicOr:    r = a | b;
            LogicXor:   r = a ^ b;
            LogicNand:  r = ~(a & b);
            LogicNor:   r = ~(a | b);
            LogicXnor:  r = ~(a ^ b);
            LogicAndn:  r = a & ~b;
            default:    r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bsg_logic_op_slot.sv
// One pipeline slot: valid bit, result and zero flag, loaded whenever adv_i is high.
module bsg_logic_op_slot
    import bsg_logic_op_pkg::*;
#(
    parameter int unsigned width_p = 64
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               adv_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    input  logic               zero_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    output logic               zero_o
);

    logic               v_q;
    logic [width_p-1:0] data_q;
    logic               zero_q;

    // Payload only moves with a valid source, so bubbles never disturb stored data.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_q    <= 1'b0;
            data_q <= '0;
            zero_q <= 1'b0;
        end else if (adv_i) begin
            v_q <= v_i;
            if (v_i) begin
                data_q <= data_i;
                zero_q <= zero_i;
            end
        end
    end

    assign v_o    = v_q;
    assign data_o = data_q;
    assign zero_o = zero_q;

endmodule

// File: rtl/bsg_logic_op_pipe.sv
// Pipelined bitwise logic unit with valid/ready flow control and bubble collapsing.
// ready_o is combinational from yumi_i so a full pipe still sustains one item per cycle.
module bsg_logic_op_pipe
    import bsg_logic_op_pkg::*;
#(
    parameter int unsigned width_p  = 64,
    parameter int unsigned stages_p = 2
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic                              v_i,
    output logic                              ready_o,
    input  logic [width_p-1:0]                a_i,
    input  logic [width_p-1:0]                b_i,
    input  logic [2:0]                        op_i,
    output logic                              v_o,
    output logic [width_p-1:0]                data_o,
    output logic                              zero_o,
    input  logic                              yumi_i,
    output logic [$clog2(stages_p+1)-1:0]     count_o
);

    localparam int unsigned cnt_w_lp = $clog2(stages_p + 1);

    bsg_logic_word_t    res_wide;
    logic [width_p-1:0] result;
    logic               result_zero;
    logic               unused_res_wide;

    assign res_wide = bsg_logic_op_eval(bsg_logic_op_max_width_gp'(a_i),
                                        bsg_logic_op_max_width_gp'(b_i),
                                        bsg_logic_op_e'(op_i));
    assign result          = res_wide[width_p-1:0];
    assign result_zero     = ~|result;
    assign unused_res_wide = ^res_wide;

    logic [stages_p-1:0] valid;
    logic [stages_p-1:0] adv;
    logic                pop;
    logic                push;

    // A stray yumi with an empty head cannot pop: it is masked here.
    assign pop = yumi_i & valid[stages_p-1];

    // Slot k advances unless it and every slot downstream are full and nothing pops.
    for (genvar k = 0; k < stages_p; k++) begin : g_adv
        assign adv[k] = pop | ~(&valid[stages_p-1:k]);
    end

    for (genvar k = 0; k < stages_p; k++) begin : g_slot
        logic               src_v;
        logic [width_p-1:0] src_data;
        logic               src_zero;
        logic               slot_v;
        logic [width_p-1:0] slot_data;
        logic               slot_zero;

        if (k == 0) begin : g_src_in
            assign src_v    = v_i;
            assign src_data = result;
            assign src_zero = result_zero;
        end else begin : g_src_prev
            assign src_v    = g_slot[k-1].slot_v;
            assign src_data = g_slot[k-1].slot_data;
            assign src_zero = g_slot[k-1].slot_zero;
        end

        bsg_logic_op_slot #(
            .width_p (width_p)
        ) u_slot (
            .clk_i     (clk_i),
            .reset_n_i (reset_n_i),
            .adv_i     (adv[k]),
            .v_i       (src_v),
            .data_i    (src_data),
            .zero_i    (src_zero),
            .v_o       (slot_v),
            .data_o    (slot_data),
            .zero_o    (slot_zero)
        );

        assign valid[k] = slot_v;
    end

    assign ready_o = adv[0];
    assign push    = v_i & ready_o;
    assign v_o     = g_slot[stages_p-1].slot_v;
    assign data_o  = g_slot[stages_p-1].slot_data;
    assign zero_o  = g_slot[stages_p-1].slot_zero;

    logic [cnt_w_lp-1:0] count_q;
    logic [cnt_w_lp-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

    yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
                                       yumi_i |-> valid[stages_p-1])
        else $error("bsg_logic_op_pipe: yumi_i asserted while v_o is low");

endmodule
